multi_hand_datapath: RTL and testbench

Parametrised successor to the two-hand card datapath. It holds NUM_HANDS hands of up to MAX_CARDS cards each and deals from a finite shoe of NUM_DECKS decks, so no rank is ever over-dealt. A request/acknowledge deal handshake replaces per-register load strobes. Per-hand baccarat scores and natural flags are kept for the game-control FSM and the display logic.

---
 rtl/baccarat_pkg.sv | 27 ++
 rtl/multi_hand_datapath_shoe_lfsr.sv | 37 +++
 rtl/multi_hand_datapath.sv | 231 +++++++++++++++++++++++
 tb/tb_multi_hand_datapath.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// baccarat_pkg
//   Types and constants shared by the multi-hand card datapath:
//   the 4-bit rank type (ACE=1 .. KING=13), the deal FSM state enum,
//   deck geometry constants and the baccarat point value of a rank.
package baccarat_pkg;

    localparam int NUM_RANKS      = 13;
    localparam int CARDS_PER_DECK = 52;

    typedef logic [3:0] rank_t;

    localparam rank_t ACE  = 4'd1;
    localparam rank_t KING = 4'd13;

    typedef enum logic [1:0] {
        IDLE,
        PICK,
        SCAN,
        WRITE
    } state_t;

    // Face cards and tens count as zero; everything else counts its pips.
    function automatic logic [3:0] card_value(input rank_t r);
        return (r <= 4'd9) ? r : 4'd0;
    endfunction

endpackage

// File: rtl/multi_hand_datapath_shoe_lfsr.sv
// shoe_lfsr
//   Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) that supplies a
//   pseudo-random candidate rank in 1..13 for the deal datapath.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - asynchronous active-high reset, loads SEED
//   rank_o  - (lfsr mod 13) + 1, combinational from the current register
module shoe_lfsr
    import baccarat_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [3:0] rank_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Shift left, feeding back the XOR of bits 16,14,13,11 (1-based).
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // The register never stops; the FSM just samples it when it needs a rank.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rank_o = 4'(lfsr_q % 16'(NUM_RANKS)) + 4'd1;

endmodule

// File: rtl/multi_hand_datapath.sv
// multi_hand_datapath
//   Holds NUM_HANDS hands of up to MAX_CARDS cards and deals from a finite
//   shoe of NUM_DECKS decks through a request/acknowledge handshake. Keeps a
//   running baccarat score and a natural flag for every hand.
// Ports:
//   slow_clock   - sole clock, rising edge
//   resetb       - asynchronous active-high reset
//   deal_req     - request one card (IDLE only), with deal_hand/force_en/force_rank
//   shuffle      - refill the shoe and clear all hands (IDLE only, top priority)
//   clear_hands  - clear all hands, shoe untouched (IDLE only)
//   busy         - state is not IDLE
//   deal_ack     - one-cycle pulse, card dealt
//   deal_nack    - one-cycle pulse, request refused
//   card_out     - rank of the last dealt card, held until the next ack
//   shoe_left    - cards remaining in the shoe
//   hand_cards   - packed slots, hand h slot s at [(h*MAX_CARDS+s)*4 +: 4]
//   hand_count   - packed per-hand card counts
//   hand_score   - packed per-hand scores 0..9
//   natural      - per hand: two cards scoring 8 or 9
module multi_hand_datapath
    import baccarat_pkg::*;
#(
    parameter int          NUM_HANDS = 2,
    parameter int          MAX_CARDS = 3,
    parameter int          NUM_DECKS = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
    localparam int         SW = $clog2(CARDS_PER_DECK * NUM_DECKS + 1),
    localparam int         CW = $clog2(MAX_CARDS + 1)
) (
    input  logic                             slow_clock,
    input  logic                             resetb,
    input  logic                             deal_req,
    input  logic [HW-1:0]                    deal_hand,
    input  logic                             force_en,
    input  logic [3:0]                       force_rank,
    input  logic                             shuffle,
    input  logic                             clear_hands,
    output logic                             busy,
    output logic                             deal_ack,
    output logic                             deal_nack,
    output logic [3:0]                       card_out,
    output logic [SW-1:0]                    shoe_left,
    output logic [NUM_HANDS*MAX_CARDS*4-1:0] hand_cards,
    output logic [NUM_HANDS*CW-1:0]          hand_count,
    output logic [NUM_HANDS*4-1:0]           hand_score,
    output logic [NUM_HANDS-1:0]             natural
);

    localparam int RW = $clog2(4 * NUM_DECKS + 1);
    localparam logic [RW-1:0] FULL_RANK = RW'(4 * NUM_DECKS);
    localparam logic [SW-1:0] FULL_SHOE = SW'(CARDS_PER_DECK * NUM_DECKS);

    state_t        state_q, state_d;
    logic [HW-1:0] hand_q, hand_d;
    logic          forceEn_q, forceEn_d;
    rank_t         forceRank_q, forceRank_d;
    rank_t         cand_q, cand_d;
    logic [RW-1:0] rankCnt_q [NUM_RANKS];
    logic [RW-1:0] rankCnt_d [NUM_RANKS];
    logic [SW-1:0] shoe_q, shoe_d;
    rank_t         slot_q [NUM_HANDS][MAX_CARDS];
    rank_t         slot_d [NUM_HANDS][MAX_CARDS];
    logic [CW-1:0] cnt_q [NUM_HANDS];
    logic [CW-1:0] cnt_d [NUM_HANDS];
    logic [3:0]    score_q [NUM_HANDS];
    logic [3:0]    score_d [NUM_HANDS];
    rank_t         card_q, card_d;
    logic          busy_q;
    logic          ack_q, ack_d;
    logic          nack_q, nack_d;

    rank_t         lfsrRank;
    logic          rejectReq;
    logic [3:0]    rankIdx;
    logic [4:0]    scoreSum;

    shoe_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk_i (slow_clock),
        .rst_i (resetb),
        .rank_o(lfsrRank)
    );

    // Next-state logic for the deal FSM and every piece of datapath state.
    // A deal commits on the SCAN hit edge so that the WRITE cycle already
    // shows the new card together with the ack pulse.
    always_comb begin
        state_d     = state_q;
        hand_d      = hand_q;
        forceEn_d   = forceEn_q;
        forceRank_d = forceRank_q;
        cand_d      = cand_q;
        rankCnt_d   = rankCnt_q;
        shoe_d      = shoe_q;
        slot_d      = slot_q;
        cnt_d       = cnt_q;
        score_d     = score_q;
        card_d      = card_q;
        ack_d       = 1'b0;
        nack_d      = 1'b0;
        rankIdx     = cand_q - 4'd1;
        scoreSum    = '0;
        rejectReq   = (int'(deal_hand) >= NUM_HANDS) ||
                      (cnt_q[deal_hand] == CW'(MAX_CARDS)) ||
                      (shoe_q == '0);

        case (state_q)
            IDLE: begin
                if (shuffle || clear_hands) begin
                    for (int h = 0; h < NUM_HANDS; h++) begin
                        for (int s = 0; s < MAX_CARDS; s++) begin
                            slot_d[h][s] = '0;
                        end
                        cnt_d[h]   = '0;
                        score_d[h] = '0;
                    end
                    if (shuffle) begin
                        for (int r = 0; r < NUM_RANKS; r++) begin
                            rankCnt_d[r] = FULL_RANK;
                        end
                        shoe_d = FULL_SHOE;
                    end
                end else if (deal_req) begin
                    if (rejectReq) begin
                        nack_d = 1'b1;
                    end else begin
                        hand_d      = deal_hand;
                        forceEn_d   = force_en;
                        forceRank_d = force_rank;
                        state_d     = PICK;
                    end
                end
            end
            PICK: begin
                if (forceEn_q) begin
                    cand_d = ((forceRank_q == 4'd0) || (forceRank_q > KING)) ? ACE : forceRank_q;
                end else begin
                    cand_d = lfsrRank;
                end
                state_d = SCAN;
            end
            SCAN: begin
                if (rankCnt_q[rankIdx] != '0) begin
                    rankCnt_d[rankIdx]         = rankCnt_q[rankIdx] - RW'(1);
                    shoe_d                     = shoe_q - SW'(1);
                    slot_d[hand_q][cnt_q[hand_q]] = cand_q;
                    cnt_d[hand_q]              = cnt_q[hand_q] + CW'(1);
                    scoreSum                   = {1'b0, score_q[hand_q]} + {1'b0, card_value(cand_q)};
                    score_d[hand_q]            = (scoreSum >= 5'd10) ? 4'(scoreSum - 5'd10) : scoreSum[3:0];
                    card_d                     = cand_q;
                    ack_d                      = 1'b1;
                    state_d                    = WRITE;
                end else begin
                    cand_d = (cand_q == KING) ? ACE : cand_q + 4'd1;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset refills the shoe and empties every hand at once.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            state_q     <= IDLE;
            hand_q      <= '0;
            forceEn_q   <= 1'b0;
            forceRank_q <= '0;
            cand_q      <= ACE;
            for (int r = 0; r < NUM_RANKS; r++) begin
                rankCnt_q[r] <= FULL_RANK;
            end
            shoe_q <= FULL_SHOE;
            for (int h = 0; h < NUM_HANDS; h++) begin
                for (int s = 0; s < MAX_CARDS; s++) begin
                    slot_q[h][s] <= '0;
                end
                cnt_q[h]   <= '0;
                score_q[h] <= '0;
            end
            card_q <= '0;
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
            nack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hand_q      <= hand_d;
            forceEn_q   <= forceEn_d;
            forceRank_q <= forceRank_d;
            cand_q      <= cand_d;
            rankCnt_q   <= rankCnt_d;
            shoe_q      <= shoe_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            score_q     <= score_d;
            card_q      <= card_d;
            busy_q      <= (state_d != IDLE);
            ack_q       <= ack_d;
            nack_q      <= nack_d;
        end
    end

    // Flatten the per-hand registers onto the output buses.
    always_comb begin
        hand_cards = '0;
        hand_count = '0;
        hand_score = '0;
        natural    = '0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            for (int s = 0; s < MAX_CARDS; s++) begin
                hand_cards[(h*MAX_CARDS+s)*4 +: 4] = slot_q[h][s];
            end
            hand_count[h*CW +: CW] = cnt_q[h];
            hand_score[h*4 +: 4]   = score_q[h];
            natural[h]             = (cnt_q[h] == CW'(2)) && (score_q[h] >= 4'd8);
        end
    end

    assign busy      = busy_q;
    assign deal_ack  = ack_q;
    assign deal_nack = nack_q;
    assign card_out  = card_q;
    assign shoe_left = shoe_q;

endmodule

// File: tb/tb_multi_hand_datapath.sv
// tb_multi_hand_datapath
//   Self-checking bench: a transaction-level model of the shoe and hands
//   predicts every registered output each cycle; a few literal checks pin
//   the model on hand-worked deals, depletion and reset.
module tb_multi_hand_datapath;

    localparam int NUM_HANDS = 2;
    localparam int MAX_CARDS = 3;
    localparam int NUM_DECKS = 1;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int HW = 1;
    localparam int SW = 6;
    localparam int CW = 2;

    localparam int K_DEAL    = 0;
    localparam int K_CLEAR   = 1;
    localparam int K_SHUFFLE = 2;
    localparam int K_BOTH    = 3;

    logic                             slow_clock = 1'b0;
    logic                             resetb;
    logic                             deal_req;
    logic [HW-1:0]                    deal_hand;
    logic                             force_en;
    logic [3:0]                       force_rank;
    logic                             shuffle;
    logic                             clear_hands;
    logic                             busy;
    logic                             deal_ack;
    logic                             deal_nack;
    logic [3:0]                       card_out;
    logic [SW-1:0]                    shoe_left;
    logic [NUM_HANDS*MAX_CARDS*4-1:0] hand_cards;
    logic [NUM_HANDS*CW-1:0]          hand_count;
    logic [NUM_HANDS*4-1:0]           hand_score;
    logic [NUM_HANDS-1:0]             natural;

    multi_hand_datapath #(
        .NUM_HANDS(NUM_HANDS),
        .MAX_CARDS(MAX_CARDS),
        .NUM_DECKS(NUM_DECKS),
        .LFSR_SEED(SEED)
    ) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .deal_req   (deal_req),
        .deal_hand  (deal_hand),
        .force_en   (force_en),
        .force_rank (force_rank),
        .shuffle    (shuffle),
        .clear_hands(clear_hands),
        .busy       (busy),
        .deal_ack   (deal_ack),
        .deal_nack  (deal_nack),
        .card_out   (card_out),
        .shoe_left  (shoe_left),
        .hand_cards (hand_cards),
        .hand_count (hand_count),
        .hand_score (hand_score),
        .natural    (natural)
    );

    always #5 slow_clock = ~slow_clock;

    int nCompared   = 0;
    int nMismatched = 0;
    bit checkEn     = 1'b0;

    // Model state
    int          mRank [1:13];
    int          mShoe;
    int          mHand [NUM_HANDS][MAX_CARDS];
    int          mCnt  [NUM_HANDS];
    int          mCard;
    bit          expAck, expNack, expBusy;
    logic [15:0] mLfsr;
    int          tally [1:13];

    // Rank-picking sequence as defined: 16-bit Fibonacci, taps 16,14,13,11.
    always @(posedge slow_clock or posedge resetb) begin
        if (resetb) mLfsr <= SEED;
        else        mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int modelScore(input int h);
        int s = 0;
        for (int k = 0; k < mCnt[h]; k++) s += (mHand[h][k] <= 9) ? mHand[h][k] : 0;
        return s % 10;
    endfunction

    function automatic void modelClear();
        for (int h = 0; h < NUM_HANDS; h++) begin
            mCnt[h] = 0;
            for (int s = 0; s < MAX_CARDS; s++) mHand[h][s] = 0;
        end
    endfunction

    function automatic void modelShuffle();
        for (int r = 1; r <= 13; r++) begin
            mRank[r] = 4 * NUM_DECKS;
            tally[r] = 0;
        end
        mShoe = 52 * NUM_DECKS;
        modelClear();
    endfunction

    function automatic void modelReset();
        modelShuffle();
        mCard   = 0;
        expAck  = 1'b0;
        expNack = 1'b0;
        expBusy = 1'b0;
    endfunction

    // Every cycle: all registered outputs and natural against the model.
    always @(negedge slow_clock) begin
        if (checkEn) begin
            checkOutput("shoe_left", int'(shoe_left), mShoe);
            checkOutput("card_out", int'(card_out), mCard);
            checkOutput("deal_ack", int'(deal_ack), int'(expAck));
            checkOutput("deal_nack", int'(deal_nack), int'(expNack));
            checkOutput("busy", int'(busy), int'(expBusy));
            for (int h = 0; h < NUM_HANDS; h++) begin
                checkOutput($sformatf("count%0d", h), int'(hand_count[h*CW +: CW]), mCnt[h]);
                checkOutput($sformatf("score%0d", h), int'(hand_score[h*4 +: 4]), modelScore(h));
                checkOutput($sformatf("natural%0d", h), int'(natural[h]),
                            int'((mCnt[h] == 2) && (modelScore(h) >= 8)));
                for (int s = 0; s < MAX_CARDS; s++)
                    checkOutput($sformatf("slot%0d_%0d", h, s),
                                int'(hand_cards[(h*MAX_CARDS+s)*4 +: 4]), mHand[h][s]);
            end
        end
    end

    // One transaction starting at the next edge; lat returns the predicted
    // request-to-ack distance in cycles, 0 when no card is dealt.
    task automatic applyStimulus(input int kind, input int hand, input bit fen,
                                 input logic [3:0] frank, output int lat);
        int cand;
        lat = 0;
        @(posedge slow_clock); #1;
        deal_req    = (kind == K_DEAL) || (kind == K_BOTH);
        shuffle     = (kind == K_SHUFFLE) || (kind == K_BOTH);
        clear_hands = (kind == K_CLEAR);
        deal_hand   = HW'(hand);
        force_en    = fen;
        force_rank  = frank;
        @(posedge slow_clock); #1;
        deal_req    = 1'b0;
        shuffle     = 1'b0;
        clear_hands = 1'b0;
        if (kind == K_SHUFFLE || kind == K_BOTH) begin
            modelShuffle();
        end else if (kind == K_CLEAR) begin
            modelClear();
        end else if (hand >= NUM_HANDS || mCnt[hand] == MAX_CARDS || mShoe == 0) begin
            expNack = 1'b1;
            @(posedge slow_clock); #1;
            expNack = 1'b0;
        end else begin
            expBusy = 1'b1;
            if (fen) cand = (frank == 0 || frank > 13) ? 1 : int'(frank);
            else     cand = int'(mLfsr % 16'd13) + 1;
            lat = 3;
            while (mRank[cand] == 0) begin
                cand = (cand == 13) ? 1 : cand + 1;
                lat++;
            end
            repeat (lat - 1) begin
                @(posedge slow_clock); #1;
            end
            mRank[cand]--;
            mShoe--;
            mHand[hand][mCnt[hand]] = cand;
            mCnt[hand]++;
            mCard  = cand;
            expAck = 1'b1;
            if (card_out >= 1 && card_out <= 13) tally[int'(card_out)]++;
            @(posedge slow_clock); #1;
            expAck  = 1'b0;
            expBusy = 1'b0;
        end
    endtask

    int lat;
    int h;
    int guard;

    initial begin
        resetb      = 1'b1;
        deal_req    = 1'b0;
        deal_hand   = '0;
        force_en    = 1'b0;
        force_rank  = '0;
        shuffle     = 1'b0;
        clear_hands = 1'b0;
        modelReset();
        repeat (2) @(posedge slow_clock);
        #1;
        resetb  = 1'b0;
        checkEn = 1'b1;

        // Reset state
        checkOutput("rst_shoe", int'(shoe_left), 52);
        checkOutput("rst_count", int'(hand_count), 0);
        checkOutput("rst_score", int'(hand_score), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_ack", int'(deal_ack), 0);
        checkOutput("rst_nack", int'(deal_nack), 0);
        checkOutput("rst_natural", int'(natural), 0);

        // Forced 7, 8, 6 to the player
        applyStimulus(K_DEAL, 0, 1'b1, 4'd7, lat);
        checkOutput("d7_lat", lat, 3);
        checkOutput("d7_score", int'(hand_score[3:0]), 7);
        applyStimulus(K_DEAL, 0, 1'b1, 4'd8, lat);
        checkOutput("d8_lat", lat, 3);
        checkOutput("d8_score", int'(hand_score[3:0]), 5);
        applyStimulus(K_DEAL, 0, 1'b1, 4'd6, lat);
        checkOutput("d6_lat", lat, 3);
        checkOutput("d6_score", int'(hand_score[3:0]), 1);
        checkOutput("d6_count", int'(hand_count[1:0]), 3);
        checkOutput("d6_shoe", int'(shoe_left), 49);

        // Fourth card to a full hand is refused
        applyStimulus(K_DEAL, 0, 1'b1, 4'd2, lat);
        checkOutput("full_count", int'(hand_count[1:0]), 3);
        checkOutput("full_shoe", int'(shoe_left), 49);
        checkOutput("full_slots", int'(hand_cards[11:0]), 12'h687);

        // Dealer natural and its loss on a third card
        applyStimulus(K_DEAL, 1, 1'b1, 4'd9, lat);
        applyStimulus(K_DEAL, 1, 1'b1, 4'd13, lat);
        checkOutput("nat_score", int'(hand_score[7:4]), 9);
        checkOutput("nat_flag", int'(natural[1]), 1);
        applyStimulus(K_DEAL, 1, 1'b1, 4'd2, lat);
        checkOutput("nat3_score", int'(hand_score[7:4]), 1);
        checkOutput("nat3_flag", int'(natural[1]), 0);

        // Randomised mix of deals, clears and shuffles
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0)      applyStimulus(K_SHUFFLE, 0, 1'b0, 4'd0, lat);
            else if (r == 1) applyStimulus(K_CLEAR, 0, 1'b0, 4'd0, lat);
            else             applyStimulus(K_DEAL, $urandom_range(0, NUM_HANDS - 1),
                                           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), lat);
        end

        // Shuffle wins over a simultaneous deal request
        applyStimulus(K_DEAL, 0, 1'b1, 4'd3, lat);
        applyStimulus(K_BOTH, 0, 1'b1, 4'd3, lat);
        checkOutput("both_shoe", int'(shoe_left), 52);
        repeat (16) begin
            @(posedge slow_clock); #1;
        end

        // Depletion: ACEs run out, then the rest of the shoe
        applyStimulus(K_SHUFFLE, 0, 1'b0, 4'd0, lat);
        for (int i = 0; i < 3; i++) applyStimulus(K_DEAL, 0, 1'b1, 4'd1, lat);
        applyStimulus(K_CLEAR, 0, 1'b0, 4'd0, lat);
        applyStimulus(K_DEAL, 0, 1'b1, 4'd1, lat);
        applyStimulus(K_DEAL, 0, 1'b1, 4'd1, lat);
        checkOutput("dep_lat", lat, 4);
        checkOutput("dep_card", int'(card_out), 2);
        guard = 0;
        while (mShoe > 0 && guard < 200) begin
            guard++;
            h = $urandom_range(0, NUM_HANDS - 1);
            if (mCnt[h] == MAX_CARDS) applyStimulus(K_CLEAR, 0, 1'b0, 4'd0, lat);
            applyStimulus(K_DEAL, h, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), lat);
        end
        for (int r = 1; r <= 13; r++) checkOutput($sformatf("tally%0d", r), tally[r], 4);
        applyStimulus(K_CLEAR, 0, 1'b0, 4'd0, lat);
        checkOutput("empty_shoe", int'(shoe_left), 0);
        applyStimulus(K_DEAL, 0, 1'b0, 4'd0, lat);
        applyStimulus(K_SHUFFLE, 0, 1'b0, 4'd0, lat);
        checkOutput("shuf_shoe", int'(shoe_left), 52);
        checkOutput("shuf_count", int'(hand_count), 0);

        // Asynchronous reset while scanning
        applyStimulus(K_DEAL, 0, 1'b1, 4'd4, lat);
        @(posedge slow_clock); #1;
        deal_req   = 1'b1;
        deal_hand  = '0;
        force_en   = 1'b1;
        force_rank = 4'd5;
        @(posedge slow_clock); #1;
        deal_req = 1'b0;
        expBusy  = 1'b1;
        @(posedge slow_clock); #1;
        checkOutput("scan_busy", int'(busy), 1);
        resetb = 1'b1;
        modelReset();
        #1;
        checkOutput("arst_shoe", int'(shoe_left), 52);
        checkOutput("arst_busy", int'(busy), 0);
        checkOutput("arst_count", int'(hand_count), 0);
        checkOutput("arst_ack", int'(deal_ack), 0);
        @(posedge slow_clock); #1;
        resetb = 1'b0;
        repeat (20) begin
            @(posedge slow_clock); #1;
        end

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
